// File: rtl/pmrq_sched_ctrl.sv
// Purpose: PMRQ controller. Allocates tags, registers dcache replays, arbitrates writeback, sequences flushes.
// Latency: allocation and grants are combinational; replay and flush pulse are 1 cycle after their cause.
// Backpressure: req_ready_o drops when no tag is FREE, the PMRQ is full, flush_i is high, or not in RUN.
//
// Ports:
//   clk_i, rstn_i                          clock, async active-low reset
//   req_valid_i/req_ready_o/req_tag_o       miss allocation handshake and lowest FREE tag
//   pmrq_full_i, pmrq_wr_o                  PMRQ full flag and tail write enable
//   resp_valid_i/resp_tag_i/resp_data_i     dcache response
//   replay_valid_o/tag_o/data_o             registered replay write into the PMRQ
//   head_done_i/head_tag_i                  PMRQ head completion and its tag
//   pipe_wb_valid_i, pipe/pmrq_wb_grant_o   writeback port arbitration
//   advance_head_o                          pop the PMRQ head
//   flush_i, pmrq_flush_o                   flush request and registered flush pulse
//   busy_o, outstanding_o, err_o            status: not RUN, non-FREE tag count, sticky error
module pmrq_sched_ctrl #(
  parameter int NUM_ENTRIES  = 8,
  parameter int TAG_WIDTH    = 3,
  parameter int DATA_WIDTH   = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  output logic [TAG_WIDTH-1:0]  req_tag_o,
  input  logic                  pmrq_full_i,
  output logic                  pmrq_wr_o,
  input  logic                  resp_valid_i,
  input  logic [TAG_WIDTH-1:0]  resp_tag_i,
  input  logic [DATA_WIDTH-1:0] resp_data_i,
  output logic                  replay_valid_o,
  output logic [TAG_WIDTH-1:0]  replay_tag_o,
  output logic [DATA_WIDTH-1:0] replay_data_o,
  input  logic                  head_done_i,
  input  logic [TAG_WIDTH-1:0]  head_tag_i,
  input  logic                  pipe_wb_valid_i,
  output logic                  pipe_wb_grant_o,
  output logic                  pmrq_wb_grant_o,
  output logic                  advance_head_o,
  input  logic                  flush_i,
  output logic                  pmrq_flush_o,
  output logic                  busy_o,
  output logic [TAG_WIDTH:0]    outstanding_o,
  output logic                  err_o
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {T_FREE, T_WAIT, T_READY, T_ZOMBIE} tag_st_e;
  typedef enum logic [1:0] {S_RUN, S_FLUSH, S_DRAIN} state_e;

  tag_st_e               tag_q [NUM_ENTRIES];
  tag_st_e               tag_d [NUM_ENTRIES];
  state_e                state_q, state_d;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic                  replay_vld_q, replay_vld_d;
  logic [TAG_WIDTH-1:0]  replay_tag_q;
  logic [DATA_WIDTH-1:0] replay_dat_q;
  logic                  flush_q, flush_d;
  logic                  err_q, err_d;
  logic [TAG_WIDTH:0]    outstanding_q, outstanding_d;

  logic                  any_free;
  logic [TAG_WIDTH-1:0]  free_idx;
  logic                  in_run;
  logic                  req_ready;
  logic                  alloc;
  logic                  starved;
  logic                  pmrq_grant;
  logic                  pipe_grant;
  logic                  any_zombie_d;

  // Lowest-index FREE tag: scan downwards so the smallest match is written last.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (tag_q[i] == T_FREE) begin
        any_free = 1'b1;
        free_idx = TAG_WIDTH'(i);
      end
    end
  end

  // Combinational outputs are gated by rstn_i so everything reads 0 while reset is held.
  assign in_run     = rstn_i & (state_q == S_RUN);
  assign req_ready  = in_run & any_free & ~pmrq_full_i & ~flush_i;
  assign alloc      = req_valid_i & req_ready;
  assign starved    = (starve_q == CNT_W'(STARVE_LIMIT));
  assign pmrq_grant = in_run & head_done_i & (~pipe_wb_valid_i | starved);
  assign pipe_grant = in_run & pipe_wb_valid_i & ~pmrq_grant;

  // Tag table next state, plus replay capture, error detection and counters.
  always_comb begin
    tag_d        = tag_q;
    err_d        = err_q;
    replay_vld_d = 1'b0;

    if (alloc) begin
      tag_d[free_idx] = T_WAIT;
    end

    // A pop on a non-READY head is a protocol error; the entry is left as is.
    if (pmrq_grant) begin
      if (tag_q[head_tag_i] == T_READY) begin
        tag_d[head_tag_i] = T_FREE;
      end else begin
        err_d = 1'b1;
      end
    end

    if (resp_valid_i) begin
      case (tag_q[resp_tag_i])
        T_WAIT: begin
          tag_d[resp_tag_i] = T_READY;
          // Responses landing in the FLUSH cycle are freed below, so no replay.
          replay_vld_d      = (state_q == S_RUN);
        end
        T_ZOMBIE: tag_d[resp_tag_i] = T_FREE;
        default:  err_d = 1'b1;
      endcase
    end

    // Flush: completed work is discarded, still-outstanding requests become zombies
    // so their tags are not reused until the stale response has drained.
    if (state_q == S_FLUSH) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (tag_d[i] == T_READY) begin
          tag_d[i] = T_FREE;
        end else if (tag_d[i] == T_WAIT) begin
          tag_d[i] = T_ZOMBIE;
        end
      end
    end

    any_zombie_d  = 1'b0;
    outstanding_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (tag_d[i] == T_ZOMBIE) begin
        any_zombie_d = 1'b1;
      end
      if (tag_d[i] != T_FREE) begin
        outstanding_d = outstanding_d + (TAG_WIDTH+1)'(1);
      end
    end

    // Starve counter only runs while the head is waiting behind the pipeline.
    starve_d = starve_q;
    if (pmrq_grant || !head_done_i || (state_q != S_RUN)) begin
      starve_d = '0;
    end else if (pipe_grant && !starved) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  // Flush sequencer.
  always_comb begin
    state_d = state_q;
    flush_d = (state_q == S_RUN) & flush_i;
    case (state_q)
      S_RUN:   if (flush_i) state_d = S_FLUSH;
      S_FLUSH: state_d = any_zombie_d ? S_DRAIN : S_RUN;
      S_DRAIN: if (!any_zombie_d) state_d = S_RUN;
      default: state_d = S_RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tag_q[i] <= T_FREE;
      end
      state_q       <= S_RUN;
      starve_q      <= '0;
      replay_vld_q  <= 1'b0;
      replay_tag_q  <= '0;
      replay_dat_q  <= '0;
      flush_q       <= 1'b0;
      err_q         <= 1'b0;
      outstanding_q <= '0;
    end else begin
      tag_q         <= tag_d;
      state_q       <= state_d;
      starve_q      <= starve_d;
      replay_vld_q  <= replay_vld_d;
      if (replay_vld_d) begin
        replay_tag_q <= resp_tag_i;
        replay_dat_q <= resp_data_i;
      end
      flush_q       <= flush_d;
      err_q         <= err_d;
      outstanding_q <= outstanding_d;
    end
  end

  assign req_ready_o     = req_ready;
  assign req_tag_o       = free_idx;
  assign pmrq_wr_o       = alloc;
  assign replay_valid_o  = replay_vld_q;
  assign replay_tag_o    = replay_tag_q;
  assign replay_data_o   = replay_dat_q;
  assign pipe_wb_grant_o = pipe_grant;
  assign pmrq_wb_grant_o = pmrq_grant;
  assign advance_head_o  = pmrq_grant;
  assign pmrq_flush_o    = flush_q;
  assign busy_o          = (state_q != S_RUN);
  assign outstanding_o   = outstanding_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_pmrq_sched_ctrl.sv
// Scoreboard bench for pmrq_sched_ctrl: stimulus queues expected events, a negedge monitor checks them.
module tb_pmrq_sched_ctrl;
  localparam int TW = 3;
  localparam int DW = 64;

  typedef struct {
    int             cyc;
    logic [TW-1:0]  tag;
    logic [DW-1:0]  data;
  } exp_t;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          req_valid_i, req_ready_o;
  logic [TW-1:0] req_tag_o;
  logic          pmrq_full_i, pmrq_wr_o;
  logic          resp_valid_i;
  logic [TW-1:0] resp_tag_i;
  logic [DW-1:0] resp_data_i;
  logic          replay_valid_o;
  logic [TW-1:0] replay_tag_o;
  logic [DW-1:0] replay_data_o;
  logic          head_done_i;
  logic [TW-1:0] head_tag_i;
  logic          pipe_wb_valid_i, pipe_wb_grant_o, pmrq_wb_grant_o, advance_head_o;
  logic          flush_i, pmrq_flush_o, busy_o, err_o;
  logic [TW:0]   outstanding_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  exp_t wr_q[$];
  exp_t rp_q[$];
  exp_t gr_q[$];   // tag[0]: 1 = PMRQ head wins, 0 = pipeline wins
  exp_t fl_q[$];

  pmrq_sched_ctrl #(.NUM_ENTRIES(8), .TAG_WIDTH(TW), .DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_tag_o(req_tag_o),
    .pmrq_full_i(pmrq_full_i), .pmrq_wr_o(pmrq_wr_o),
    .resp_valid_i(resp_valid_i), .resp_tag_i(resp_tag_i), .resp_data_i(resp_data_i),
    .replay_valid_o(replay_valid_o), .replay_tag_o(replay_tag_o), .replay_data_o(replay_data_o),
    .head_done_i(head_done_i), .head_tag_i(head_tag_i),
    .pipe_wb_valid_i(pipe_wb_valid_i), .pipe_wb_grant_o(pipe_wb_grant_o),
    .pmrq_wb_grant_o(pmrq_wb_grant_o), .advance_head_o(advance_head_o),
    .flush_i(flush_i), .pmrq_flush_o(pmrq_flush_o),
    .busy_o(busy_o), .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic alloc(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      tick();
      req_valid_i = 1'b1;
      wr_q.push_back('{cyc, TW'(first + i), '0});
    end
    tick();
    req_valid_i = 1'b0;
  endtask

  task automatic push_resp(input int tag, input logic [DW-1:0] data, input bit exp_replay);
    resp_valid_i = 1'b1;
    resp_tag_i   = TW'(tag);
    resp_data_i  = data;
    if (exp_replay) rp_q.push_back('{cyc + 1, TW'(tag), data});
  endtask

  // Monitor: every DUT event must match the oldest queued expectation, including its cycle.
  always @(negedge clk_i) begin
    exp_t e;
    if (pmrq_wr_o) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 64'(pmrq_wr_o), 0);
      else begin
        e = wr_q.pop_front();
        chk("wr_tag", 64'(req_tag_o), 64'(e.tag));
        chk("wr_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (replay_valid_o) begin
      if (rp_q.size() == 0) chk("replay_unexpected", 64'(replay_valid_o), 0);
      else begin
        e = rp_q.pop_front();
        chk("replay_tag", 64'(replay_tag_o), 64'(e.tag));
        chk("replay_data", replay_data_o, e.data);
        chk("replay_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (pipe_wb_grant_o || pmrq_wb_grant_o) begin
      chk("grant_exclusive", 64'(pipe_wb_grant_o & pmrq_wb_grant_o), 0);
      if (gr_q.size() == 0) chk("grant_unexpected", 64'(pmrq_wb_grant_o), 64'(~pipe_wb_grant_o));
      else begin
        e = gr_q.pop_front();
        chk("grant_pmrq", 64'(pmrq_wb_grant_o), 64'(e.tag[0]));
        chk("advance_head", 64'(advance_head_o), 64'(e.tag[0]));
        chk("grant_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (pmrq_flush_o) begin
      if (fl_q.size() == 0) chk("flush_unexpected", 64'(pmrq_flush_o), 0);
      else begin
        e = fl_q.pop_front();
        chk("flush_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog timeout actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with requests and grant demands applied: everything must read 0.
    rstn_i = 1'b0; req_valid_i = 1'b1; pmrq_full_i = 1'b0; resp_valid_i = 1'b0;
    resp_tag_i = '0; resp_data_i = '0; head_done_i = 1'b1; head_tag_i = '0;
    pipe_wb_valid_i = 1'b1; flush_i = 1'b0;
    #3;
    chk("rst_req_ready", 64'(req_ready_o), 0);
    chk("rst_pipe_grant", 64'(pipe_wb_grant_o), 0);
    chk("rst_pmrq_grant", 64'(pmrq_wb_grant_o), 0);
    chk("rst_wr", 64'(pmrq_wr_o), 0);
    chk("rst_busy", 64'(busy_o), 0);
    chk("rst_outstanding", 64'(outstanding_o), 0);
    chk("rst_err", 64'(err_o), 0);
    chk("rst_replay", 64'(replay_valid_o), 0);
    chk("rst_flush", 64'(pmrq_flush_o), 0);
    tick();
    req_valid_i = 1'b0; head_done_i = 1'b0; pipe_wb_valid_i = 1'b0; rstn_i = 1'b1;
    #2;
    chk("post_rst_ready", 64'(req_ready_o), 1);
    chk("post_rst_tag", 64'(req_tag_o), 0);

    // Three misses -> tags 0,1,2; response to tag 1 replays one cycle later.
    alloc(3, 0);
    push_resp(1, 64'hDEAD, 1'b1);
    #2;
    chk("outstanding_3", 64'(outstanding_o), 3);

    // Fill tags 3..7, then the queue is out of tags.
    for (int i = 0; i < 5; i++) begin
      tick();
      resp_valid_i = 1'b0;
      req_valid_i  = 1'b1;
      wr_q.push_back('{cyc, TW'(3 + i), '0});
    end
    tick();
    push_resp(0, 64'h100, 1'b1);
    #2;
    chk("full_ready", 64'(req_ready_o), 0);
    chk("outstanding_8", 64'(outstanding_o), 8);
    tick();
    resp_valid_i = 1'b0; head_done_i = 1'b1; head_tag_i = 3'd0;
    gr_q.push_back('{cyc, 3'd1, '0});
    #2;
    chk("pop_cycle_ready", 64'(req_ready_o), 0);
    tick();
    head_done_i = 1'b0;
    wr_q.push_back('{cyc, 3'd0, '0});
    #2;
    chk("realloc_ready", 64'(req_ready_o), 1);
    chk("realloc_tag", 64'(req_tag_o), 0);
    tick();
    req_valid_i = 1'b0;

    // Starvation: tags 1 and 2 READY; both requesters held for 10 cycles.
    push_resp(2, 64'h222, 1'b1);
    for (int k = 0; k < 10; k++) begin
      tick();
      resp_valid_i = 1'b0; head_done_i = 1'b1; pipe_wb_valid_i = 1'b1;
      head_tag_i = (k < 5) ? 3'd1 : 3'd2;
      gr_q.push_back('{cyc, (k == 4 || k == 9) ? 3'd1 : 3'd0, '0});
    end
    tick();
    head_done_i = 1'b0; pipe_wb_valid_i = 1'b0;
    chk("err_clean_after_arb", 64'(err_o), 0);
    rstn_i = 1'b0;
    tick();
    rstn_i = 1'b1;

    // Flush with tag 0 READY and tags 1,2 WAIT; both stragglers drain silently.
    alloc(3, 0);
    push_resp(0, 64'hA0, 1'b1);
    tick();
    resp_valid_i = 1'b0; flush_i = 1'b1; req_valid_i = 1'b1;
    fl_q.push_back('{cyc + 1, '0, '0});
    #2;
    chk("flush_refuses_alloc", 64'(req_ready_o), 0);
    tick();
    flush_i = 1'b0;
    #2;
    chk("flush_busy", 64'(busy_o), 1);
    chk("flush_err", 64'(err_o), 0);
    tick();
    push_resp(1, 64'h11, 1'b0);
    #2;
    chk("drain_busy", 64'(busy_o), 1);
    chk("drain_ready", 64'(req_ready_o), 0);
    tick();
    push_resp(2, 64'h22, 1'b0);
    #2;
    chk("drain_last_busy", 64'(busy_o), 1);
    tick();
    resp_valid_i = 1'b0; req_valid_i = 1'b0;
    #2;
    chk("drain_done_busy", 64'(busy_o), 0);
    chk("drain_done_outstanding", 64'(outstanding_o), 0);
    chk("drain_done_ready", 64'(req_ready_o), 1);

    // Response on a FREE tag: no replay, sticky error.
    tick();
    push_resp(5, 64'h55, 1'b0);
    tick();
    resp_valid_i = 1'b0;
    #2;
    chk("err_set", 64'(err_o), 1);
    repeat (3) tick();
    chk("err_sticky", 64'(err_o), 1);

    // Reset while draining two zombies.
    alloc(2, 0);
    flush_i = 1'b1;
    fl_q.push_back('{cyc + 1, '0, '0});
    tick();
    flush_i = 1'b0;
    tick();
    #2;
    chk("zombie_busy", 64'(busy_o), 1);
    chk("zombie_outstanding", 64'(outstanding_o), 2);
    rstn_i = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy_o), 0);
    chk("mid_rst_outstanding", 64'(outstanding_o), 0);
    chk("mid_rst_err", 64'(err_o), 0);
    chk("mid_rst_ready", 64'(req_ready_o), 0);
    tick();
    rstn_i = 1'b1;
    #2;
    chk("after_rst_ready", 64'(req_ready_o), 1);
    chk("after_rst_tag", 64'(req_tag_o), 0);
    chk("after_rst_busy", 64'(busy_o), 0);

    tick();
    tick();
    chk("wr_q_drained", 64'(wr_q.size()), 0);
    chk("rp_q_drained", 64'(rp_q.size()), 0);
    chk("gr_q_drained", 64'(gr_q.size()), 0);
    chk("fl_q_drained", 64'(fl_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
